// File: rtl/onchip_memory_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onchip_memory_dp : true dual-port byte-enabled RAM, 1- or 2-cycle read latency
// Rev 1.0
// ---------------------------------------------------------------------------
module onchip_memory_dp #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 13,
   parameter int DEPTH        = 5000,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "onchip_memory_dp.hex"
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clken,
   input  logic [ADDR_W-1:0]   s1_address,
   input  logic                s1_chipselect,
   input  logic                s1_read,
   input  logic                s1_write,
   input  logic [DATA_W/8-1:0] s1_byteenable,
   input  logic [DATA_W-1:0]   s1_writedata,
   output logic [DATA_W-1:0]   s1_readdata,
   output logic                s1_readdatavalid,
   input  logic [ADDR_W-1:0]   s2_address,
   input  logic                s2_chipselect,
   input  logic                s2_read,
   input  logic                s2_write,
   input  logic [DATA_W/8-1:0] s2_byteenable,
   input  logic [DATA_W-1:0]   s2_writedata,
   output logic [DATA_W-1:0]   s2_readdata,
   output logic                s2_readdatavalid
);

   localparam int              c_BE_W    = DATA_W / 8;
   localparam int              c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] c_DEPTH_X = (ADDR_W + 1)'(DEPTH);
   // Contents are loaded by the device configuration flow, not by logic here.
   localparam int              c_init_file_unused_bits = $bits(INIT_FILE);

   logic [DATA_W-1:0]  mem_q [DEPTH];

   logic [ADDR_W-1:0]  w_addr     [2];
   logic [c_IDX_W-1:0] w_idx      [2];
   logic               w_cs       [2];
   logic               w_rd       [2];
   logic               w_wr       [2];
   logic [c_BE_W-1:0]  w_be       [2];
   logic [DATA_W-1:0]  w_wdata    [2];
   logic               w_in_range [2];
   logic               w_wr_acc   [2];
   logic               w_rd_acc   [2];
   logic [DATA_W-1:0]  w_rd_word  [2];
   logic               w_out_v    [2];
   logic [DATA_W-1:0]  w_out_data [2];

   logic               rvalid_q   [2];
   logic               rvalid_d   [2];
   logic [DATA_W-1:0]  rdata_q    [2];
   logic [DATA_W-1:0]  rdata_d    [2];

   assign w_addr[0]  = s1_address;
   assign w_cs[0]    = s1_chipselect;
   assign w_rd[0]    = s1_read;
   assign w_wr[0]    = s1_write;
   assign w_be[0]    = s1_byteenable;
   assign w_wdata[0] = s1_writedata;
   assign w_addr[1]  = s2_address;
   assign w_cs[1]    = s2_chipselect;
   assign w_rd[1]    = s2_read;
   assign w_wr[1]    = s2_write;
   assign w_be[1]    = s2_byteenable;
   assign w_wdata[1] = s2_writedata;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_in_range[p] = ({1'b0, w_addr[p]} < c_DEPTH_X);
         w_idx[p]      = w_addr[p][c_IDX_W-1:0];
         w_wr_acc[p]   = clken & w_cs[p] & w_wr[p];
         w_rd_acc[p]   = clken & w_cs[p] & w_rd[p] & ~w_wr[p];
      end
   end

   // Read word with the other port's same-cycle write lanes merged in.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd_word[p] = w_in_range[p] ? mem_q[w_idx[p]] : '0;
         if (w_in_range[p] && w_wr_acc[1-p] && (w_addr[1-p] == w_addr[p])) begin
            for (int b = 0; b < c_BE_W; b++) begin
               if (w_be[1-p][b]) begin
                  w_rd_word[p][8*b +: 8] = w_wdata[1-p][8*b +: 8];
               end
            end
         end
      end
   end

   // Port 2 is assigned first so port 1 wins any lane both ports enable.
   always_ff @(posedge clk) begin
      if (w_wr_acc[1] && w_in_range[1]) begin
         for (int b = 0; b < c_BE_W; b++) begin
            if (w_be[1][b]) begin
               mem_q[w_idx[1]][8*b +: 8] <= w_wdata[1][8*b +: 8];
            end
         end
      end
      if (w_wr_acc[0] && w_in_range[0]) begin
         for (int b = 0; b < c_BE_W; b++) begin
            if (w_be[0][b]) begin
               mem_q[w_idx[0]][8*b +: 8] <= w_wdata[0][8*b +: 8];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic              pipe_v_q [2];
         logic [DATA_W-1:0] pipe_d_q [2];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int p = 0; p < 2; p++) begin
                  pipe_v_q[p] <= 1'b0;
                  pipe_d_q[p] <= '0;
               end
            end else if (clken) begin
               for (int p = 0; p < 2; p++) begin
                  pipe_v_q[p] <= w_rd_acc[p];
                  pipe_d_q[p] <= w_rd_word[p];
               end
            end
         end

         always_comb begin
            for (int p = 0; p < 2; p++) begin
               w_out_v[p]    = pipe_v_q[p];
               w_out_data[p] = pipe_d_q[p];
            end
         end
      end else begin : g_lat1
         always_comb begin
            for (int p = 0; p < 2; p++) begin
               w_out_v[p]    = w_rd_acc[p];
               w_out_data[p] = w_rd_word[p];
            end
         end
      end
   endgenerate

   // readdata only moves on a valid beat so it holds the last returned word.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rvalid_d[p] = w_out_v[p];
         rdata_d[p]  = w_out_v[p] ? w_out_data[p] : rdata_q[p];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 2; p++) begin
            rvalid_q[p] <= 1'b0;
            rdata_q[p]  <= '0;
         end
      end else if (clken) begin
         for (int p = 0; p < 2; p++) begin
            rvalid_q[p] <= rvalid_d[p];
            rdata_q[p]  <= rdata_d[p];
         end
      end
   end

   assign s1_readdata      = rdata_q[0];
   assign s1_readdatavalid = rvalid_q[0];
   assign s2_readdata      = rdata_q[1];
   assign s2_readdatavalid = rvalid_q[1];

endmodule
`default_nettype wire

// File: tb/tb_onchip_memory_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_onchip_memory_dp : scoreboard bench driving a latency-1 and a latency-2 instance
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_onchip_memory_dp;

   localparam int DW    = 32;
   localparam int AW    = 13;
   localparam int DEPTH = 5000;
   localparam int BW    = DW / 8;

   typedef struct {
      int unsigned due;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          clken;
   logic          cs [2];
   logic          rd [2];
   logic          wr [2];
   logic [AW-1:0] ad [2];
   logic [BW-1:0] be [2];
   logic [DW-1:0] wd [2];
   logic [DW-1:0] rdat [4];
   logic          rval [4];

   onchip_memory_dp #(.READ_LATENCY(1)) u_lat1 (
      .clk(clk), .reset_n(reset_n), .clken(clken),
      .s1_address(ad[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
      .s1_byteenable(be[0]), .s1_writedata(wd[0]),
      .s1_readdata(rdat[0]), .s1_readdatavalid(rval[0]),
      .s2_address(ad[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
      .s2_byteenable(be[1]), .s2_writedata(wd[1]),
      .s2_readdata(rdat[1]), .s2_readdatavalid(rval[1])
   );

   onchip_memory_dp #(.READ_LATENCY(2)) u_lat2 (
      .clk(clk), .reset_n(reset_n), .clken(clken),
      .s1_address(ad[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
      .s1_byteenable(be[0]), .s1_writedata(wd[0]),
      .s1_readdata(rdat[2]), .s1_readdatavalid(rval[2]),
      .s2_address(ad[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
      .s2_byteenable(be[1]), .s2_writedata(wd[1]),
      .s2_readdata(rdat[3]), .s2_readdatavalid(rval[3])
   );

   // Streams 0/1: latency-1 ports 1/2; streams 2/3: latency-2 ports 1/2.
   exp_t          sb_q [4][$];
   int            checks   = 0;
   int            failures = 0;
   int unsigned   ecyc     = 0;
   logic          en_edge  = 1'b0;
   int            beats [4];
   logic [DW-1:0] mem_m [DEPTH];
   bit            ovr [2];
   logic [DW-1:0] ovr_val [2];
   logic [DW-1:0] last_d [4];
   logic [DW-1:0] prev_d [4];
   logic          prev_v [4];

   task automatic idle();
      clken = 1'b1;
      for (int p = 0; p < 2; p++) begin
         cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
         ad[p] = '0;   be[p] = '0;   wd[p] = '0;
         ovr[p] = 1'b0; ovr_val[p] = '0;
      end
   endtask

   task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic [DW-1:0] d);
      cs[p] = 1'b1; wr[p] = 1'b1; rd[p] = 1'b0; ad[p] = a; be[p] = b; wd[p] = d;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0; ad[p] = a;
   endtask

   task automatic expect_rd(input int p, input logic [DW-1:0] v);
      ovr[p] = 1'b1; ovr_val[p] = v;
   endtask

   // Apply the reference rules for the upcoming edge, then let that edge happen.
   task automatic step();
      logic          we [2];
      logic [DW-1:0] nw [2];
      logic [DW-1:0] v;
      exp_t          e;
      if (clken && reset_n) begin
         for (int p = 0; p < 2; p++) we[p] = cs[p] && wr[p];
         for (int p = 0; p < 2; p++) begin
            nw[p] = (ad[p] < DEPTH) ? mem_m[ad[p]] : '0;
            for (int b = 0; b < BW; b++) begin
               if (we[0] && ad[0] == ad[p] && be[0][b])      nw[p][8*b +: 8] = wd[0][8*b +: 8];
               else if (we[1] && ad[1] == ad[p] && be[1][b]) nw[p][8*b +: 8] = wd[1][8*b +: 8];
            end
         end
         for (int p = 0; p < 2; p++) if (we[p] && ad[p] < DEPTH) mem_m[ad[p]] = nw[p];
         for (int p = 0; p < 2; p++) begin
            if (cs[p] && rd[p] && !wr[p]) begin
               v = (ad[p] < DEPTH) ? mem_m[ad[p]] : '0;
               if (ovr[p]) v = ovr_val[p];
               e.data = v;
               e.due  = ecyc + 1;
               sb_q[p].push_back(e);
               e.due  = ecyc + 2;
               sb_q[p+2].push_back(e);
            end
         end
      end
      ovr[0] = 1'b0; ovr[1] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      idle();
      for (int s = 0; s < 4; s++) sb_q[s].delete();
      repeat (n) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5)      return AW'($urandom_range(0, 15));
      else if (k <= 7) return AW'($urandom_range(4992, 4999));
      else if (k == 8) return AW'($urandom_range(5000, 5003));
      else             return AW'($urandom_range(8188, 8191));
   endfunction

   initial begin
      for (int s = 0; s < 4; s++) begin
         last_d[s] = '0; prev_d[s] = '0; prev_v[s] = 1'b0; beats[s] = 0;
      end
      forever begin
         @(posedge clk);
         en_edge = clken && reset_n;
         if (en_edge) ecyc++;
         @(negedge clk);
         for (int s = 0; s < 4; s++) begin
            if (!reset_n) begin
               checks++;
               if (rval[s] !== 1'b0 || rdat[s] !== '0) begin
                  failures++;
                  $display("FAIL reset_state s%0d: valid=%0b data=%h, required valid=0 data=0",
                           s, rval[s], rdat[s]);
               end
               last_d[s] = '0;
            end else if (en_edge) begin
               if (rval[s] === 1'b1) begin
                  checks++;
                  if (sb_q[s].size() == 0 || sb_q[s][0].due != ecyc) begin
                     failures++;
                     $display("FAIL unexpected_valid s%0d cyc=%0d: data=%h, required no valid",
                              s, ecyc, rdat[s]);
                  end else begin
                     if (rdat[s] !== sb_q[s][0].data) begin
                        failures++;
                        $display("FAIL read_data s%0d cyc=%0d: got %h, required %h",
                                 s, ecyc, rdat[s], sb_q[s][0].data);
                     end
                     void'(sb_q[s].pop_front());
                     beats[s]++;
                  end
                  last_d[s] = rdat[s];
               end else begin
                  if (sb_q[s].size() > 0 && sb_q[s][0].due <= ecyc) begin
                     checks++;
                     failures++;
                     $display("FAIL missing_valid s%0d cyc=%0d: valid=%b, required 1 with %h",
                              s, ecyc, rval[s], sb_q[s][0].data);
                     void'(sb_q[s].pop_front());
                  end
                  checks++;
                  if (rdat[s] !== last_d[s]) begin
                     failures++;
                     $display("FAIL hold_data s%0d: got %h, required %h", s, rdat[s], last_d[s]);
                  end
               end
            end else begin
               checks++;
               if (rval[s] !== prev_v[s] || rdat[s] !== prev_d[s]) begin
                  failures++;
                  $display("FAIL clken_freeze s%0d: valid=%b data=%h, required valid=%b data=%h",
                           s, rval[s], rdat[s], prev_v[s], prev_d[s]);
               end
            end
            prev_v[s] = rval[s];
            prev_d[s] = rdat[s];
         end
      end
   end

   initial begin
      int b0 [4];
      reset_n = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Give every in-range address in the random pool a known value.
      for (int i = 0; i < 16; i += 2) begin
         idle();
         set_wr(0, AW'(i), 4'hF, $urandom);
         set_wr(1, AW'(i + 1), 4'hF, $urandom);
         step();
      end
      for (int i = 4992; i < 5000; i += 2) begin
         idle();
         set_wr(0, AW'(i), 4'hF, $urandom);
         set_wr(1, AW'(i + 1), 4'hF, $urandom);
         step();
      end

      // Write on port 1, read back on port 2.
      idle(); set_wr(0, 13'd5, 4'hF, 32'hDEADBEEF); step();
      idle(); set_rd(1, 13'd5); expect_rd(1, 32'hDEADBEEF); step();

      // Partial byte-enable merge.
      idle(); set_wr(0, 13'd7, 4'hF, 32'h11223344); step();
      idle(); set_wr(0, 13'd7, 4'h5, 32'hAABBCCDD); step();
      idle(); set_rd(0, 13'd7); expect_rd(0, 32'h11BB33DD); step();
      idle(); set_wr(1, 13'd7, 4'h0, 32'hFFFFFFFF); step();
      idle(); set_rd(1, 13'd7); expect_rd(1, 32'h11BB33DD); step();

      // Same-address dual writes: port 1 wins shared lanes.
      idle(); set_wr(0, 13'd9, 4'h3, 32'h0000FFFF); set_wr(1, 13'd9, 4'hF, 32'hFFFF0000); step();
      idle(); set_rd(0, 13'd9); expect_rd(0, 32'hFFFFFFFF); step();
      idle(); set_wr(0, 13'd9, 4'hF, 32'h12345678); step();
      idle(); set_wr(0, 13'd9, 4'h3, 32'h0000FFFF); set_wr(1, 13'd9, 4'h3, 32'hFFFF0000); step();
      idle(); set_rd(1, 13'd9); expect_rd(1, 32'h1234FFFF); step();

      // Cross-port forwarding and read+write treated as write only.
      idle(); set_wr(0, 13'd11, 4'hF, 32'hCAFEF00D); set_rd(1, 13'd11);
      expect_rd(1, 32'hCAFEF00D); step();
      idle(); set_wr(1, 13'd12, 4'hF, 32'h0F0F0F0F); step();
      idle(); set_wr(1, 13'd12, 4'hC, 32'hA5A50000); set_rd(0, 13'd12);
      expect_rd(0, 32'hA5A50F0F); step();
      idle(); set_wr(0, 13'd12, 4'hF, 32'h77777777); rd[0] = 1'b1; step();
      idle(); set_rd(0, 13'd12); expect_rd(0, 32'h77777777); step();

      // Out-of-range accesses.
      idle(); set_wr(0, 13'd0, 4'hF, 32'h00C0FFEE); step();
      idle(); set_rd(0, 13'd5000); expect_rd(0, 32'h0); step();
      idle(); set_wr(0, 13'd5000, 4'hF, 32'hFFFFFFFF); set_wr(1, 13'd8191, 4'hF, 32'h55555555); step();
      idle(); set_rd(0, 13'd0); expect_rd(0, 32'h00C0FFEE);
      set_rd(1, 13'd5000); expect_rd(1, 32'h0); step();

      // Continuous reads on both ports with a 3-cycle clken gap.
      idle(); step(); step();
      for (int s = 0; s < 4; s++) b0[s] = beats[s];
      for (int i = 0; i < 19; i++) begin
         idle();
         set_rd(0, AW'($urandom_range(0, 15)));
         set_rd(1, AW'($urandom_range(4992, 4999)));
         clken = !(i >= 7 && i <= 9);
         step();
      end
      idle(); repeat (4) step();
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (beats[s] - b0[s] != 16) begin
            failures++;
            $display("FAIL stream_count s%0d: got %0d valids, required 16", s, beats[s] - b0[s]);
         end
      end

      // Reset one cycle after a read is accepted.
      idle(); set_wr(0, 13'd3, 4'hF, 32'h3C3C3C3C); step();
      idle(); set_rd(0, 13'd3); set_rd(1, 13'd3); step();
      do_reset(2);
      idle(); set_rd(0, 13'd3); expect_rd(0, 32'h3C3C3C3C);
      set_rd(1, 13'd3); expect_rd(1, 32'h3C3C3C3C); step();
      idle(); repeat (3) step();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if (i == 200 || i == 400) do_reset($urandom_range(1, 3));
         idle();
         clken = ($urandom_range(0, 9) != 0);
         for (int p = 0; p < 2; p++) begin
            int op;
            op    = $urandom_range(0, 3);
            cs[p] = ($urandom_range(0, 7) != 0);
            rd[p] = (op != 2);
            wr[p] = (op >= 2);
            ad[p] = pick_addr();
            be[p] = BW'($urandom);
            wd[p] = $urandom;
         end
         if ($urandom_range(0, 2) == 0) ad[1] = ad[0];
         step();
      end

      idle(); repeat (6) step();
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (sb_q[s].size() != 0) begin
            failures++;
            $display("FAIL leftover s%0d: %0d reads never returned, required 0", s, sb_q[s].size());
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/onchip_memory_dp.md
ONCHIP_MEMORY_DP -- requirements
Module: onchip_memory_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 13, word-address width.
REQ-003 SHALL have parameter DEPTH, default 5000, number of words; DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter READ_LATENCY, default 1, read latency in cycles; legal values 1 and 2.
REQ-005 SHALL have parameter INIT_FILE, default "onchip_memory_dp.hex", power-up memory contents.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clken, input, 1, global clock enable; 0 freezes the block.
REQ-009 SHALL have port s1_address, input, ADDR_W, port-1 word address.
REQ-010 SHALL have port s1_chipselect, input, 1, port-1 select.
REQ-011 SHALL have port s1_read, input, 1, port-1 read request.
REQ-012 SHALL have port s1_write, input, 1, port-1 write request.
REQ-013 SHALL have port s1_byteenable, input, DATA_W/8, port-1 byte lanes.
REQ-014 SHALL have port s1_writedata, input, DATA_W, port-1 write data.
REQ-015 SHALL have port s1_readdata, output, DATA_W, port-1 read data.
REQ-016 SHALL have port s1_readdatavalid, output, 1, port-1 read data qualifier.
REQ-017 SHALL have ports s2_address through s2_readdatavalid, identical in direction, width and meaning to REQ-009..REQ-016, for port 2.

Function
REQ-018 SHALL accept a read on port N when clken & sN_chipselect & sN_read, and a write when clken & sN_chipselect & sN_write; both asserted together counts as a write only.
REQ-019 SHALL update only the byte lanes whose sN_byteenable bit is 1 on a write; a write with byteenable all-zero leaves memory unchanged.
REQ-020 SHALL present read data on sN_readdata with sN_readdatavalid = 1 exactly READ_LATENCY enabled cycles after acceptance, for one cycle per accepted read.
REQ-021 SHALL support back-to-back reads on every cycle on both ports independently (full throughput, no waitrequest).
REQ-022 SHALL hold all pipeline registers, readdata and readdatavalid unchanged while clken = 0, and perform no memory write.
REQ-023 SHALL return old data for a same-port read-during-write to the same address.
REQ-024 SHALL return new (byte-merged) data for a port reading an address written by the other port in the same cycle.
REQ-025 SHALL, when both ports write the same address in the same cycle, commit port-1 lanes over port-2 lanes where both byteenables are set; other lanes are taken from whichever port enables them.
REQ-026 SHALL ignore writes to addresses >= DEPTH and return 0 (with readdatavalid) for reads of them.
REQ-027 SHALL hold sN_readdata at its last valid value while sN_readdatavalid = 0.

Reset
REQ-028 SHALL, on reset_n low, asynchronously clear sN_readdatavalid to 0, sN_readdata to 0 and all in-flight read pipeline stages.
REQ-029 SHALL drop reads in flight when reset asserts mid-operation; no readdatavalid for them after release.
REQ-030 SHALL NOT modify memory contents on reset; INIT_FILE contents apply only at configuration.
REQ-031 SHALL accept requests on the first rising edge after reset_n deasserts.

Verification
REQ-032 Write 0xDEADBEEF to s1 addr 5 (byteenable 0xF), then s2 read addr 5 -> s2_readdatavalid high READ_LATENCY cycles later, s2_readdata = 0xDEADBEEF.
REQ-033 Addr 7 holds 0x11223344; s1 write 0xAABBCCDD byteenable 0x5 -> subsequent read = 0x11BB33DD.
REQ-034 Same cycle: s1 writes 0x0000FFFF be 0x3, s2 writes 0xFFFF0000 be 0xF to addr 9 -> read = 0xFFFFFFFF; with s2 be 0x3 instead -> low half 0xFFFF from s1.
REQ-035 READ_LATENCY = 2, reads on both ports every cycle for 16 cycles, clken low for 3 cycles mid-stream -> 16 valids per port, in order, none lost or duplicated.
REQ-036 Read addr DEPTH (5000) -> readdata 0 with valid; write to it then read addr 5000-8192 alias 0 region -> addr 0 unchanged.
REQ-037 Issue read, assert reset_n low one cycle later -> readdatavalid stays 0, readdata 0; memory value at that address unchanged after release.
